mem_exc_ctrl: RTL and testbench
===============================

# mem_exc_ctrl

MEM-stage exception resolver and flush sequencer; it is the producer side of the CP0 exception interface. Each cycle it combines the per-instruction exception flags carried down the pipeline with CP0 Status/Cause/EPC, with WB-stage CP0 writes forwarded in. From these it emits the final exception type, the faulting instruction address and the delay-slot flag to CP0. It also issues a one-cycle pipeline flush with the redirect PC, then masks further exceptions while the killed instructions drain.

## Interface
- EXC_VECTOR, 32'h0000_0040, redirect PC for every exception except eret.
- DRAIN_CYCLES, 2, number of cycles after a flush during which no new exception is accepted (0 to 7).
- CP0_STATUS_ADDR / CP0_CAUSE_ADDR / CP0_EPC_ADDR, 12 / 13 / 14, CP0 register numbers used for forwarding.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- exc_flags_i  in  32  pipeline exception flags:
  - bit 8 syscall; bit 9 invalid instruction; bit 10 trap; bit 11 overflow; bit 12 eret.
  - All other bits are ignored.
- inst_valid_i  in  1  MEM holds a real instruction (0 = bubble).
- inst_addr_i  in  32  PC of the MEM instruction.
- is_in_delayslot_i  in  1  MEM instruction sits in a delay slot.
- cp0_status_i / cp0_cause_i / cp0_epc_i  in  32 each  current CP0 register values.
- wb_cp0_we_i, wb_cp0_waddr_i[4:0], wb_cp0_wdata_i[31:0]  in  WB-stage CP0 write, used for forwarding.
- exception_type_o  out  32  final type code: 0x0 none, 0x1 interrupt, 0x8 syscall, 0xA invalid instruction, 0xD trap, 0xC overflow, 0xE eret.
- exc_inst_addr_o  out  32  inst_addr_i passed through. CP0 applies the delay-slot −4 correction, not this block.
- exc_delayslot_o  out  1  is_in_delayslot_i passed through.
- flush_o  out  1  one-cycle pipeline flush.
- new_pc_o  out  32  redirect PC, valid while flush_o = 1.
- irq_pending_o  out  1  interrupt condition is true but not yet taken.
- exc_count_o  out  16  count of flushes taken, wraps.

## Operation
- Effective CP0 values (forwarding):
  - Status: wb_cp0_wdata_i if wb_cp0_we_i and the WB address is STATUS, else cp0_status_i.
  - Cause: cp0_cause_i with bits [9:8], [22] and [23] replaced from wb_cp0_wdata_i when WB writes CAUSE.
  - EPC: fully replaced by wb_cp0_wdata_i when WB writes EPC.
- Interrupt condition irq = Status[0] (IE) & ~Status[1] (EXL) & |(Cause[15:8] & Status[15:8]). All operands are effective values.
- irq_pending_o = irq & ~accept, where accept = state IDLE & inst_valid_i & ~rst.
- When accept is true, the type is chosen by fixed priority: interrupt (irq) > syscall > invalid > trap > overflow > eret.
  - If none of these applies, the type is 0x0.
  - When accept is false, exception_type_o = 0x0, flush_o = 0 and new_pc_o = 0.
- For any non-zero type: flush_o = 1.
  - new_pc_o = effective EPC for eret, EXC_VECTOR for all other types.
- State machine (IDLE, DRAIN):
  - IDLE to DRAIN on a flush when DRAIN_CYCLES > 0, loading a 3-bit counter with DRAIN_CYCLES−1.
  - With DRAIN_CYCLES = 0 the block stays in IDLE, so back-to-back flushes are allowed.
  - DRAIN: the counter decrements every cycle; exceptions and flags are ignored. The transition to IDLE happens on the cycle the counter equals 0.
- exc_count_o increments by 1 on every cycle with flush_o = 1 and wraps from 0xFFFF to 0x0000.

## Timing
- Type, address, delay-slot, flush and new_pc outputs are combinational from the inputs and the current state, so CP0 and the PC logic see them in the same cycle the instruction is in MEM.
- The state, the drain counter and exc_count_o are registered.
- Reset (rst = 1):
  - Combinational outputs are forced to 0 during reset, including irq_pending_o.
  - At the next edge: state = IDLE, counter = 0, exc_count_o = 0.
  - Reset during DRAIN aborts the drain; the first cycle after reset can accept an exception.
- Flush cadence: with DRAIN_CYCLES = N > 0, a flush at cycle t blocks cycles t+1 … t+N; the earliest next flush is at t+N+1.
- A bubble (inst_valid_i = 0) never takes an exception, even an interrupt. irq_pending_o stays high until a valid instruction arrives in IDLE or irq drops.
- Forwarding applies in the same cycle as the WB write, with no extra latency.

## Test plan
- Syscall, DRAIN_CYCLES = 2:
  - Stimulus: Status = 0x1000_0000, flags = 0x100, addr = 0x100, valid.
  - Required: type 0x8, flush 1, new_pc 0x40, exc_inst_addr 0x100, exc_count_o becomes 1.
  - Required: flags = 0x800 in the next two cycles give type 0 and flush 0; in the third cycle they give type 0xC.
- Interrupt on a bubble:
  - Stimulus: Status = 0x0000_0401, Cause = 0x0000_0400, valid = 0.
  - Required: type 0, irq_pending 1.
  - Next cycle with valid = 1 and addr = 0x204, delayslot = 1: type 0x1, exc_inst_addr 0x204, exc_delayslot 1, pending 0.
- Priority:
  - Stimulus: irq true together with flags = 0x0900 (syscall and overflow).
  - Required: type 0x1.
  - With irq false and flags = 0x1E00: type 0xA.
- Eret forwarding:
  - Stimulus: flags = 0x1000, cp0_epc_i = 0, WB writes EPC = 0x0000_1234 in the same cycle.
  - Required: type 0xE, new_pc 0x1234.
- EXL masking via forwarding:
  - Stimulus: irq true from cp0_status_i while WB writes Status = 0x0000_0403.
  - Required: type 0, irq_pending 0.
- Reset mid-drain and counter wrap:
  - Stimulus: assert rst one cycle into DRAIN.
  - Required: outputs 0, exc_count_o = 0, and a syscall in the cycle after reset flushes.
  - Separately, 65536 flushes return exc_count_o to 0.

Source files
------------

// File: rtl/mem_exc_ctrl.sv
// mem_exc_ctrl: MEM-stage exception resolver and flush sequencer feeding CP0.
//   clk, rst                     clock, synchronous active-high reset
//   exc_flags_i                  per-instruction flags (8 syscall, 9 invalid, 10 trap, 11 overflow, 12 eret)
//   inst_valid_i/inst_addr_i     MEM instruction valid and PC
//   is_in_delayslot_i            MEM instruction is in a delay slot
//   cp0_status/cause/epc_i       current CP0 registers
//   wb_cp0_we/waddr/wdata_i      WB-stage CP0 write, forwarded
//   exception_type_o             resolved type code to CP0
//   exc_inst_addr_o/exc_delayslot_o  faulting PC and delay-slot flag
//   flush_o/new_pc_o             one-cycle flush and redirect PC
//   irq_pending_o                interrupt true but not taken this cycle
//   exc_count_o                  wrapping count of flushes
module mem_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR      = 32'h0000_0040,
    parameter int          DRAIN_CYCLES    = 2,
    parameter int          CP0_STATUS_ADDR = 12,
    parameter int          CP0_CAUSE_ADDR  = 13,
    parameter int          CP0_EPC_ADDR    = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] exc_flags_i,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_wdata_i,
    output logic [31:0] exception_type_o,
    output logic [31:0] exc_inst_addr_o,
    output logic        exc_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        irq_pending_o,
    output logic [15:0] exc_count_o
);
    typedef enum logic {IDLE, DRAIN} state_t;
    // Only the software-interrupt and IV/BD-style bits of Cause are writable.
    localparam logic [31:0] CAUSE_FWD_MASK = 32'h00C0_0300;
    localparam logic [2:0]  DRAIN_LOAD     = 3'(DRAIN_CYCLES - 1);
    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [15:0] count_q, count_d;
    logic        wb_status, wb_cause, wb_epc;
    logic [31:0] status, cause, epc, type_raw;
    logic        irq, accept, unused_bits;
    assign wb_status = wb_cp0_we_i && wb_cp0_waddr_i == 5'(CP0_STATUS_ADDR);
    assign wb_cause  = wb_cp0_we_i && wb_cp0_waddr_i == 5'(CP0_CAUSE_ADDR);
    assign wb_epc    = wb_cp0_we_i && wb_cp0_waddr_i == 5'(CP0_EPC_ADDR);
    assign status = wb_status ? wb_cp0_wdata_i : cp0_status_i;
    assign cause  = wb_cause ? (cp0_cause_i & ~CAUSE_FWD_MASK) | (wb_cp0_wdata_i & CAUSE_FWD_MASK) : cp0_cause_i;
    assign epc    = wb_epc ? wb_cp0_wdata_i : cp0_epc_i;
    assign irq    = status[0] & ~status[1] & |(cause[15:8] & status[15:8]);
    assign accept = state_q == IDLE && inst_valid_i && !rst;
    always_comb begin
        type_raw = irq            ? 32'h1 :
                   exc_flags_i[8]  ? 32'h8 :
                   exc_flags_i[9]  ? 32'hA :
                   exc_flags_i[10] ? 32'hD :
                   exc_flags_i[11] ? 32'hC :
                   exc_flags_i[12] ? 32'hE : 32'h0;
    end
    assign exception_type_o = accept ? type_raw : '0;
    assign flush_o          = exception_type_o != '0;
    assign new_pc_o         = !flush_o ? '0 : exception_type_o == 32'hE ? epc : EXC_VECTOR;
    assign exc_inst_addr_o  = rst ? '0 : inst_addr_i;
    assign exc_delayslot_o  = !rst && is_in_delayslot_i;
    assign irq_pending_o    = irq && !accept && !rst;
    assign count_d          = flush_o ? count_q + 16'd1 : count_q;
    assign exc_count_o      = count_q;
    assign unused_bits = ^{exc_flags_i[31:13], exc_flags_i[7:0], status[31:16], status[7:2],
                           cause[31:16], cause[7:0]};
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (state_q == IDLE) begin
                if (flush_o && DRAIN_CYCLES > 0) begin
                    state_q <= DRAIN;
                    cnt_q   <= DRAIN_LOAD;
                end
            end else begin
                cnt_q <= cnt_q == '0 ? '0 : cnt_q - 3'd1;
                if (cnt_q == '0) state_q <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mem_exc_ctrl.sv
// tb_mem_exc_ctrl: scoreboard bench for mem_exc_ctrl (DRAIN_CYCLES 2 and 0).
module tb_mem_exc_ctrl;
    typedef struct packed {
        logic [31:0] typ;
        logic [31:0] addr;
        logic        ds;
        logic        flush;
        logic [31:0] pc;
        logic        pend;
    } out_t;
    logic        clk = 0, rst = 1;
    logic [31:0] flags, addr, status, cause, epc, wdata;
    logic        valid, ds, we;
    logic [4:0]  waddr;
    logic [31:0] typ_o, eaddr_o, pc_o, b_typ, b_eaddr, b_pc;
    logic        ds_o, flush_o, pend_o, b_ds, b_flush, b_pend;
    logic [15:0] cnt_o, b_cnt;
    out_t        obs, e;
    out_t        exp_q[$];
    int          assertions = 0, failures = 0;
    assign obs = {typ_o, eaddr_o, ds_o, flush_o, pc_o, pend_o};
    always #5 clk = ~clk;
    mem_exc_ctrl dut (
        .clk(clk), .rst(rst), .exc_flags_i(flags), .inst_valid_i(valid), .inst_addr_i(addr),
        .is_in_delayslot_i(ds), .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc),
        .wb_cp0_we_i(we), .wb_cp0_waddr_i(waddr), .wb_cp0_wdata_i(wdata),
        .exception_type_o(typ_o), .exc_inst_addr_o(eaddr_o), .exc_delayslot_o(ds_o),
        .flush_o(flush_o), .new_pc_o(pc_o), .irq_pending_o(pend_o), .exc_count_o(cnt_o));
    mem_exc_ctrl #(.DRAIN_CYCLES(0)) dut_b2b (
        .clk(clk), .rst(rst), .exc_flags_i(flags), .inst_valid_i(valid), .inst_addr_i(addr),
        .is_in_delayslot_i(ds), .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc),
        .wb_cp0_we_i(we), .wb_cp0_waddr_i(waddr), .wb_cp0_wdata_i(wdata),
        .exception_type_o(b_typ), .exc_inst_addr_o(b_eaddr), .exc_delayslot_o(b_ds),
        .flush_o(b_flush), .new_pc_o(b_pc), .irq_pending_o(b_pend), .exc_count_o(b_cnt));
    function automatic out_t mk(logic [31:0] t, logic [31:0] a, logic d, logic f, logic [31:0] p, logic q);
        return {t, a, d, f, p, q};
    endfunction
    task automatic next();
        @(posedge clk);
        #1;
    endtask
    task automatic zero_inputs();
        flags = 0; addr = 0; status = 0; cause = 0; epc = 0; wdata = 0;
        valid = 0; ds = 0; we = 0; waddr = 0;
    endtask
    task automatic drain_out();
        zero_inputs();
        repeat (3) next();
    endtask
    task automatic test_reset();
        zero_inputs();
        rst = 1; valid = 1; flags = 32'h100; addr = 32'h44; ds = 1; status = 32'h401; cause = 32'h400;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        @(negedge clk); e = exp_q.pop_front(); assertions++;
        if (obs !== e) begin failures++; $display("FAIL reset_outputs: got %h exp %h", obs, e); end
        next();
        @(negedge clk); assertions++;
        if (cnt_o !== 16'd0) begin failures++; $display("FAIL reset_count: got %h exp 0", cnt_o); end
        rst = 0;
        drain_out();
    endtask
    task automatic test_syscall();
        status = 32'h1000_0000; flags = 32'h100; addr = 32'h100; valid = 1;
        exp_q.push_back(mk(32'h8, 32'h100, 0, 1, 32'h40, 0));
        @(negedge clk); e = exp_q.pop_front(); assertions++;
        if (obs !== e) begin failures++; $display("FAIL syscall_take: got %h exp %h", obs, e); end
        next();
        flags = 32'h800; addr = 32'h104;
        for (int i = 0; i < 2; i++) exp_q.push_back(mk(0, 32'h104, 0, 0, 0, 0));
        exp_q.push_back(mk(32'hC, 32'h104, 0, 1, 32'h40, 0));
        @(negedge clk); assertions++;
        if (cnt_o !== 16'd1) begin failures++; $display("FAIL syscall_count: got %h exp 1", cnt_o); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            e = exp_q.pop_front(); assertions++;
            if (obs !== e) begin failures++; $display("FAIL drain_cycle%0d: got %h exp %h", i, obs, e); end
            next();
        end
        @(negedge clk); assertions++;
        if (cnt_o !== 16'd2) begin failures++; $display("FAIL drain_count: got %h exp 2", cnt_o); end
        drain_out();
    endtask
    task automatic test_irq_bubble();
        status = 32'h401; cause = 32'h400; valid = 0; addr = 32'h200;
        exp_q.push_back(mk(0, 32'h200, 0, 0, 0, 1));
        @(negedge clk); e = exp_q.pop_front(); assertions++;
        if (obs !== e) begin failures++; $display("FAIL irq_bubble: got %h exp %h", obs, e); end
        next();
        valid = 1; addr = 32'h204; ds = 1;
        exp_q.push_back(mk(32'h1, 32'h204, 1, 1, 32'h40, 0));
        @(negedge clk); e = exp_q.pop_front(); assertions++;
        if (obs !== e) begin failures++; $display("FAIL irq_take: got %h exp %h", obs, e); end
        next();
        addr = 32'h208; ds = 0;
        exp_q.push_back(mk(0, 32'h208, 0, 0, 0, 1));
        @(negedge clk); e = exp_q.pop_front(); assertions++;
        if (obs !== e) begin failures++; $display("FAIL irq_in_drain: got %h exp %h", obs, e); end
        drain_out();
    endtask
    task automatic test_priority();
        status = 32'h401; cause = 32'h400; flags = 32'h0900; valid = 1; addr = 32'h300;
        exp_q.push_back(mk(32'h1, 32'h300, 0, 1, 32'h40, 0));
        @(negedge clk); e = exp_q.pop_front(); assertions++;
        if (obs !== e) begin failures++; $display("FAIL prio_irq: got %h exp %h", obs, e); end
        drain_out();
        flags = 32'h1E00; valid = 1; addr = 32'h304;
        exp_q.push_back(mk(32'hA, 32'h304, 0, 1, 32'h40, 0));
        @(negedge clk); e = exp_q.pop_front(); assertions++;
        if (obs !== e) begin failures++; $display("FAIL prio_invalid: got %h exp %h", obs, e); end
        drain_out();
    endtask
    task automatic test_forwarding();
        flags = 32'h1000; epc = 0; we = 1; waddr = 5'd14; wdata = 32'h1234; valid = 1; addr = 32'h400;
        exp_q.push_back(mk(32'hE, 32'h400, 0, 1, 32'h1234, 0));
        @(negedge clk); e = exp_q.pop_front(); assertions++;
        if (obs !== e) begin failures++; $display("FAIL eret_fwd: got %h exp %h", obs, e); end
        drain_out();
        status = 32'h401; cause = 32'h400; we = 1; waddr = 5'd12; wdata = 32'h403; valid = 1; addr = 32'h404;
        exp_q.push_back(mk(0, 32'h404, 0, 0, 0, 0));
        @(negedge clk); e = exp_q.pop_front(); assertions++;
        if (obs !== e) begin failures++; $display("FAIL exl_fwd: got %h exp %h", obs, e); end
        next();
        status = 32'h101; cause = 0; waddr = 5'd13; wdata = 32'h100; addr = 32'h408;
        exp_q.push_back(mk(32'h1, 32'h408, 0, 1, 32'h40, 0));
        @(negedge clk); e = exp_q.pop_front(); assertions++;
        if (obs !== e) begin failures++; $display("FAIL cause_sw_fwd: got %h exp %h", obs, e); end
        drain_out();
        status = 32'h401; cause = 0; we = 1; waddr = 5'd13; wdata = 32'h400; valid = 1; addr = 32'h40C;
        exp_q.push_back(mk(0, 32'h40C, 0, 0, 0, 0));
        @(negedge clk); e = exp_q.pop_front(); assertions++;
        if (obs !== e) begin failures++; $display("FAIL cause_hw_masked: got %h exp %h", obs, e); end
        drain_out();
    endtask
    task automatic test_reset_mid_drain();
        flags = 32'h100; valid = 1; addr = 32'h500;
        next();
        rst = 1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        @(negedge clk); e = exp_q.pop_front(); assertions++;
        if (obs !== e) begin failures++; $display("FAIL mid_drain_reset: got %h exp %h", obs, e); end
        next();
        rst = 0;
        exp_q.push_back(mk(32'h8, 32'h500, 0, 1, 32'h40, 0));
        @(negedge clk); e = exp_q.pop_front(); assertions++;
        if (obs !== e) begin failures++; $display("FAIL after_reset_take: got %h exp %h", obs, e); end
        assertions++;
        if (cnt_o !== 16'd0) begin failures++; $display("FAIL after_reset_count: got %h exp 0", cnt_o); end
        drain_out();
    endtask
    task automatic test_back_to_back();
        rst = 1;
        next();
        rst = 0; flags = 32'h100; valid = 1; addr = 32'h600;
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            if (i == 1) begin
                assertions++;
                if ({b_flush, flush_o} !== 2'b10) begin
                    failures++; $display("FAIL b2b_flush: got %b exp 10", {b_flush, flush_o});
                end
            end
            if (i == 65535) begin
                assertions++;
                if (b_cnt !== 16'hFFFF) begin failures++; $display("FAIL count_max: got %h exp ffff", b_cnt); end
            end
            next();
        end
        @(negedge clk); assertions++;
        if (b_cnt !== 16'd0) begin failures++; $display("FAIL count_wrap: got %h exp 0", b_cnt); end
        drain_out();
    endtask
    initial begin
        zero_inputs();
        test_reset();
        test_syscall();
        test_irq_bubble();
        test_priority();
        test_forwarding();
        test_reset_mid_drain();
        test_back_to_back();
        assertions++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover: got %0d exp 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
